// File: rtl/spi_wrapper.sv
// SPI slave front end plus single-port byte RAM: 10-bit frames carry an opcode and a data/address byte.
// Latency: rx_valid 1 clk after the 10th bit; MISO starts 2 clks after rx_valid for a read-data frame.
// No backpressure: SS_n high aborts a frame or read-back at the next edge; one frame per SS_n assertion.

module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid
);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] bit_cnt;
  logic       rd_flag;
  logic [7:0] tx_shift;
  logic [3:0] tx_cnt;
  logic       shifting;

  assign shifting = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: the command bit picks the branch and is then dropped; SS_n high always returns to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!SS_n) next_state = CHK_CMD;
      CHK_CMD:   next_state = !MOSI ? WRITE : (rd_flag ? READ_DATA : READ_ADD);
      WRITE:     next_state = WRITE;
      READ_ADD:  next_state = READ_ADD;
      READ_DATA: next_state = READ_DATA;
      default:   next_state = IDLE;
    endcase
    if (SS_n) next_state = IDLE;
  end

  // Frame capture: 10 bits MSB first, then the counter parks at 10 until SS_n releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 4'd0;
      rx_data  <= 10'd0;
      rx_valid <= 1'b0;
      rd_flag  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n || !shifting) begin
        bit_cnt <= 4'd0;
      end else if (bit_cnt < 4'd10) begin
        rx_data <= {rx_data[8:0], MOSI};
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd9) begin
          rx_valid <= 1'b1;
          if (state == READ_ADD)       rd_flag <= 1'b1;
          else if (state == READ_DATA) rd_flag <= 1'b0;
        end
      end
    end
  end

  // Read-back serializer: MSB goes out the clock after tx_valid, MISO idles low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MISO     <= 1'b0;
      tx_shift <= 8'd0;
      tx_cnt   <= 4'd0;
    end else if (SS_n) begin
      MISO   <= 1'b0;
      tx_cnt <= 4'd0;
    end else if (tx_valid) begin
      MISO     <= tx_data[7];
      tx_shift <= {tx_data[6:0], 1'b0};
      tx_cnt   <= 4'd7;
    end else if (tx_cnt != 4'd0) begin
      MISO     <= tx_shift[7];
      tx_shift <= {tx_shift[6:0], 1'b0};
      tx_cnt   <= tx_cnt - 4'd1;
    end else begin
      MISO <= 1'b0;
    end
  end

endmodule

module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;

  // Address registers and read port; the top two frame bits alone pick the action
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (rx_data[9:8])
          2'b00:   wr_addr <= rx_data[ADDR_SIZE-1:0];
          2'b10:   rd_addr <= rx_data[ADDR_SIZE-1:0];
          2'b11: begin
            tx_data  <= mem[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Storage write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rx_valid && (rx_data[9:8] == 2'b01)) mem[wr_addr] <= rx_data[7:0];
  end

endmodule

module spi_wrapper #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  spi_slave SLAVE (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  spi_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) RAM (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_spi_wrapper.sv
// Randomized frame-level stimulus against a byte-array model of the SPI RAM.
// Expected rx frames and read-back bytes are queued by the driver and popped by a monitor.
// The monitor also requires MISO low whenever no read-back bit is due.

module tb_spi_wrapper;

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  always #5 clk = ~clk;

  spi_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  typedef struct {
    logic [7:0] b;
    int         nb;
  } txe_t;

  int         vec  = 0;
  int         errs = 0;
  txe_t       txq[$];
  logic [9:0] rxq[$];
  logic [7:0] mdl [256];
  bit         known [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  bit         m_flag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: MISO bit stream, tx_valid and rx_valid events against queued expectations
  int   pos = 8;
  txe_t cur;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (pos < 8) begin
          check("miso_bit", {31'd0, MISO}, (pos < cur.nb) ? {31'd0, cur.b[7-pos]} : 32'd0);
          pos++;
        end else begin
          check("miso_idle", {31'd0, MISO}, 32'd0);
        end
        if (dut.tx_valid) begin
          if (txq.size() == 0) check("unexpected_tx_valid", 32'd1, 32'd0);
          else begin
            cur = txq.pop_front();
            pos = 0;
          end
        end
        if (dut.rx_valid) begin
          if (rxq.size() == 0) check("unexpected_rx_valid", 32'd1, 32'd0);
          else check("rx_frame", {22'd0, dut.rx_data}, {22'd0, rxq.pop_front()});
        end
      end
    end
  end

  // One SS_n assertion: select, command bit, 10 frame bits (or abort before bit abort_at), hold, release
  task automatic frame(input bit cmd, input logic [1:0] op, input logic [7:0] data,
                       input int abort_at, input int hold);
    logic [9:0] bits;
    bit         aborted;
    int         nb;
    txe_t       e;
    bits    = {op, data};
    aborted = 1'b0;
    @(negedge clk); SS_n = 1'b0; MOSI = 1'($urandom);
    @(negedge clk); MOSI = cmd;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        SS_n    = 1'b1;
        aborted = 1'b1;
        break;
      end
      MOSI = bits[9-i];
    end
    if (!aborted) begin
      rxq.push_back(bits);
      if (cmd) m_flag = ~m_flag;
      case (op)
        2'b00: m_wr = data;
        2'b01: begin mdl[m_wr] = data; known[m_wr] = 1'b1; end
        2'b10: m_rd = data;
        default: begin
          nb = hold - 1;
          if (nb > 8) nb = 8;
          e.b  = mdl[m_rd];
          e.nb = nb;
          txq.push_back(e);
        end
      endcase
      repeat (hold) begin @(negedge clk); MOSI = 1'($urandom); end
      @(negedge clk); SS_n = 1'b1;
    end
    repeat (2) begin @(negedge clk); MOSI = 1'($urandom); end
    check("rd_flag", {31'd0, dut.SLAVE.rd_flag}, {31'd0, m_flag});
    check("wr_addr", {24'd0, dut.RAM.wr_addr}, {24'd0, m_wr});
    check("rd_addr", {24'd0, dut.RAM.rd_addr}, {24'd0, m_rd});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_wr = 8'd0; m_rd = 8'd0; m_flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      SS_n = 1'($urandom); MOSI = 1'($urandom);
      check("reset_miso", {31'd0, MISO}, 32'd0);
      check("reset_rx_valid", {31'd0, dut.rx_valid}, 32'd0);
      check("reset_tx_valid", {31'd0, dut.tx_valid}, 32'd0);
      check("reset_rd_flag", {31'd0, dut.SLAVE.rd_flag}, 32'd0);
      check("reset_wr_addr", {24'd0, dut.RAM.wr_addr}, 32'd0);
      check("reset_rd_addr", {24'd0, dut.RAM.rd_addr}, 32'd0);
    end
    SS_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk); MOSI = 1'($urandom);
      check("idle_rx_valid", {31'd0, dut.rx_valid}, 32'd0);
    end
  endtask

  task automatic check_mem();
    for (int a = 0; a < 256; a++)
      if (known[a]) check("mem", {24'd0, dut.RAM.mem[a]}, {24'd0, mdl[a]});
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] data;
    bit         cmd;
    int         ab;
    int         hold;
    for (int a = 0; a < 256; a++) known[a] = 1'b0;
    SS_n = 1'b1; MOSI = 1'b0; rst_n = 1'b1;
    do_reset();

    // Directed: write address, write data, read address, read data, then READ_ADD again
    frame(1'b0, 2'b00, 8'h05, -1, 1);
    frame(1'b0, 2'b01, 8'hAA, -1, 1);
    check_mem();
    frame(1'b1, 2'b10, 8'h05, -1, 1);
    frame(1'b1, 2'b11, 8'h00, -1, 10);
    frame(1'b1, 2'b10, 8'h05, -1, 1);
    // Abort a write-data frame after 5 bits, then a read-back cut short after 3 bits
    frame(1'b0, 2'b01, 8'h55, 5, 1);
    check_mem();
    frame(1'b1, 2'b11, 8'h00, -1, 4);
    frame(1'b0, 2'b00, 8'hFF, -1, 2);
    frame(1'b0, 2'b01, 8'h3C, -1, 2);

    // Randomized traffic with occasional command/opcode mismatch and aborts
    for (int n = 0; n < 70; n++) begin
      op   = 2'($urandom);
      data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      if (op == 2'b11 && !known[m_rd]) op = 2'b01;
      cmd  = ($urandom_range(0, 4) == 0) ? ~op[1] : op[1];
      ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      hold = (op == 2'b11) ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 3));
      frame(cmd, op, data, ab, hold);
    end

    repeat (12) @(negedge clk);
    do_reset();
    check_mem();
    frame(1'b1, 2'b10, 8'h05, -1, 1);
    frame(1'b1, 2'b11, 8'h00, -1, 9);

    repeat (20) @(negedge clk);
    check("rx_queue_drained", txq.size() + rxq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/spi_wrapper.md
SPI_WRAPPER -- requirements
Module: spi_wrapper

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, the number of RAM words.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, the RAM address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port SS_n, input, 1 bit: slave select, active-low; high aborts any transaction.
REQ-006 SHALL have port MOSI, input, 1 bit: serial data in, sampled on clk rising edge, MSB first.
REQ-007 SHALL have port MISO, output, 1 bit: serial data out, registered, MSB first.
REQ-008 SHALL contain a RAM sub-instance named RAM holding an 8-bit x MEM_DEPTH array named mem, so a bench can preload it with $readmemh.

Function
REQ-009 SHALL be built from an SPI slave and a single-port RAM. The slave supplies rx_data[9:0] and rx_valid. The RAM returns tx_data[7:0] and tx_valid.
REQ-010 SHALL implement the slave FSM with states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-011 SHALL make these FSM transitions:
- IDLE: SS_n=0 -> CHK_CMD; otherwise stay in IDLE.
- CHK_CMD: MOSI=0 -> WRITE.
- CHK_CMD: MOSI=1 with read-address flag clear -> READ_ADD.
- CHK_CMD: MOSI=1 with read-address flag set -> READ_DATA.
- The MOSI bit sampled in CHK_CMD is not stored.
REQ-012 SHALL, in WRITE, READ_ADD and READ_DATA, shift one MOSI bit per clock into rx_data, MSB first, for exactly 10 clocks.
REQ-013 SHALL pulse rx_valid high for exactly one clock, in the cycle after the 10th bit is captured.
REQ-014 SHALL set the read-address flag when a READ_ADD frame completes, and clear it when a READ_DATA frame completes.
REQ-015 SHALL, in any state, go to IDLE on the next edge when SS_n=1. The bit counter clears, no rx_valid is produced, and a partial frame is discarded.
REQ-016 SHALL have the RAM act on rx_valid according to rx_data[9:8]:
- 00: wr_addr <= rx_data[7:0].
- 01: mem[wr_addr] <= rx_data[7:0].
- 10: rd_addr <= rx_data[7:0].
- 11: tx_data <= mem[rd_addr] and tx_valid=1 for one clock; rx_data[7:0] is ignored.
REQ-017 SHALL, on tx_valid, latch tx_data in the slave and drive it on MISO starting the next clock. The order is tx_data[7] first, one bit per clock, 8 bits, while SS_n stays low.
REQ-018 SHALL hold MISO at 0 whenever it is not shifting read data.
REQ-019 SHALL tolerate SS_n rising during the MISO shift: the shift stops, MISO returns to 0, and the read-address flag stays cleared.
REQ-020 SHALL use only ADDR_SIZE address bits, so addresses are modulo MEM_DEPTH.
REQ-021 SHALL give any command-bit/opcode mismatch no special handling; rx_data[9:8] alone selects the RAM action.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronously), force:
- FSM state to IDLE and the bit counter to 0.
- rx_data, rx_valid and the read-address flag to 0.
- wr_addr, rd_addr, tx_data and tx_valid to 0.
- MISO to 0.
REQ-023 SHALL NOT clear or alter mem contents on reset.
REQ-024 SHALL ignore SS_n and MOSI during reset and resume in IDLE on the first edge after rst_n rises.

Verification
REQ-025 SHALL cover reset idle: rst_n=0 then 1, SS_n=1, random MOSI for 5 clocks -> MISO=0, state IDLE, mem unchanged.
REQ-026 SHALL cover write address: SS_n=0, MOSI=0, then bits 00_00000101 (10 clocks), then SS_n=1 -> wr_addr=0x05; one rx_valid pulse.
REQ-027 SHALL cover write data: SS_n=0, MOSI=0, then bits 01_10101010, then SS_n=1 -> mem[5]=0xAA.
REQ-028 SHALL cover read address: SS_n=0, MOSI=1, then bits 10_00000101, then SS_n=1 -> rd_addr=0x05, read-address flag=1.
REQ-029 SHALL cover read data: SS_n=0, MOSI=1, then bits 11_00000000, with SS_n held low for 20 clocks -> MISO serially outputs 1,0,1,0,1,0,1,0 and the flag clears. A following MOSI=1 command goes to READ_ADD.
REQ-030 SHALL cover abort: SS_n raised after 5 bits of a write-data frame -> no rx_valid, mem unchanged, FSM in IDLE next clock.
